ws2812b_pixel_rx: RTL and testbench

//  Receive side of the WS2812B single-wire protocol that led_ring_driver transmits. Behaves as one pixel:
//  - captures the first 24 bits of each frame (GRB, MSB first);
//  - regenerates all later bits on dout for downstream pixels.

---
 rtl/ws2812b_pkg.sv | 43 ++++
 rtl/ws2812b_bit_slicer.sv | 94 +++++++++
 rtl/ws2812b_pixel_rx.sv | 120 ++++++++++++
 tb/tb_ws2812b_pixel_rx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ws2812b_pkg
// Description : Shared WS2812B timing constants, receiver state encoding,
//               slicer event bundle and a shift helper. Used by both the
//               ring driver (TX) and the pixel receiver (RX) so that the
//               two sides always agree on bit timing.
// Revision    : 1.0 - initial release
// ============================================================================
package ws2812b_pkg;

    // Bit timing at a 10 MHz clock
    localparam int c_t0h_cyc      = 4;     // '0' high time
    localparam int c_t0l_cyc      = 9;     // '0' low time
    localparam int c_t1h_cyc      = 8;     // '1' high time
    localparam int c_t1l_cyc      = 5;     // '1' low time
    localparam int c_thresh_cyc   = 6;     // high >= this decodes as '1'
    localparam int c_min_high_cyc = 2;     // shorter high is a glitch
    localparam int c_max_high_cyc = 12;    // longer high is a protocol error
    localparam int c_reset_cyc    = 500;   // low time that latches / ends a frame
    localparam int c_pixel_bits   = 24;    // G,R,B x 8

    // Receiver state encoding
    localparam logic [1:0] c_st_rx_own  = 2'd0;
    localparam logic [1:0] c_st_forward = 2'd1;
    localparam logic [1:0] c_st_error   = 2'd2;

    // Per-cycle events produced by the bit slicer
    typedef struct packed {
        logic bit_val;      // decoded value of the bit that just ended
        logic bit_strobe;   // a bit ended this cycle (falling edge of din_s)
        logic glitch;       // the high pulse that just ended was too short
        logic stuck;        // din_s has been high for too long
        logic gap;          // low time just reached the frame-end length
    } slicer_ev_t;

    // Shift one decoded bit into the colour register, MSB first
    function automatic logic [23:0] shift_in_bit(input logic [23:0] cur, input logic b);
        return {cur[22:0], b};
    endfunction

endpackage : ws2812b_pkg
`default_nettype wire

// File: rtl/ws2812b_bit_slicer.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_bit_slicer
// Description : Synchronises the asynchronous WS2812B line, measures high
//               and low pulse widths and turns them into per-cycle bit,
//               glitch, stuck-high and frame-gap events.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_bit_slicer #(
    parameter int THRESH_CYC   = 6,
    parameter int MIN_HIGH_CYC = 2,
    parameter int MAX_HIGH_CYC = 12,
    parameter int RESET_CYC    = 500
) (
    input  logic clk,
    input  logic res_n,
    input  logic din,
    output logic din_s,
    output logic bit_val,
    output logic bit_strobe,
    output logic glitch,
    output logic stuck,
    output logic gap
);

    localparam int c_hi_w = $clog2(MAX_HIGH_CYC + 2);
    localparam int c_lo_w = $clog2(RESET_CYC + 1);

    localparam logic [c_hi_w-1:0] c_hi_one    = c_hi_w'(1);
    localparam logic [c_hi_w-1:0] c_hi_sat    = c_hi_w'(MAX_HIGH_CYC + 1);
    localparam logic [c_hi_w-1:0] c_hi_thresh = c_hi_w'(THRESH_CYC);
    localparam logic [c_hi_w-1:0] c_hi_min    = c_hi_w'(MIN_HIGH_CYC);
    localparam logic [c_lo_w-1:0] c_lo_one    = c_lo_w'(1);
    localparam logic [c_lo_w-1:0] c_lo_sat    = c_lo_w'(RESET_CYC);
    localparam logic [c_lo_w-1:0] c_lo_gap    = c_lo_w'(RESET_CYC - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_din_d;
    logic [c_hi_w-1:0] r_hi_cnt;
    logic [c_lo_w-1:0] r_lo_cnt;
    logic              w_rise;
    logic              w_fall;

    // Two-flop synchroniser plus a one-cycle delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_din_d <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_din_d <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_din_d;
    assign w_fall = ~r_sync2 & r_din_d;

    // High-time counter: restarts at the rise (the rise cycle counts as the
    // first high cycle), so on the fall it holds the exact high width
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_hi_cnt <= '0;
        end else if (w_rise) begin
            r_hi_cnt <= c_hi_one;
        end else if (r_sync2 && (r_hi_cnt != c_hi_sat)) begin
            r_hi_cnt <= r_hi_cnt + c_hi_one;
        end
    end

    // Low-time counter: restarts at the fall, saturates at the gap length
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_lo_cnt <= '0;
        end else if (w_fall) begin
            r_lo_cnt <= c_lo_one;
        end else if (!r_sync2 && (r_lo_cnt != c_lo_sat)) begin
            r_lo_cnt <= r_lo_cnt + c_lo_one;
        end
    end

    // The edge cycles are excluded from stuck/gap because the counter
    // register still holds the width of the previous opposite-level pulse.
    assign din_s      = r_sync2;
    assign bit_strobe = w_fall;
    assign bit_val    = (r_hi_cnt >= c_hi_thresh);
    assign glitch     = w_fall && (r_hi_cnt < c_hi_min);
    assign stuck      = r_sync2 && !w_rise && (r_hi_cnt == c_hi_sat);
    assign gap        = !r_sync2 && !w_fall && (r_lo_cnt == c_lo_gap);

endmodule : ws2812b_bit_slicer
`default_nettype wire

// File: rtl/ws2812b_pixel_rx.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_pixel_rx
// Description : One WS2812B pixel. Captures the first 24 bits of a frame as
//               a GRB colour and forwards every later bit on dout, delayed
//               by the synchroniser but with its high width untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_pixel_rx
    import ws2812b_pkg::*;
#(
    parameter int THRESH_CYC   = c_thresh_cyc,
    parameter int MIN_HIGH_CYC = c_min_high_cyc,
    parameter int MAX_HIGH_CYC = c_max_high_cyc,
    parameter int RESET_CYC    = c_reset_cyc
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        din,
    output logic        dout,
    output logic [23:0] pixel_grb,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        bit_err,
    output logic        busy
);

    localparam logic [4:0] c_last_bit_idx = 5'(c_pixel_bits - 1);

    logic        w_din_s;
    slicer_ev_t  w_ev;
    logic [23:0] w_next_shift;

    logic [1:0]  r_state;
    logic [4:0]  r_bit_idx;
    logic [23:0] r_shift;

    ws2812b_bit_slicer #(
        .THRESH_CYC   (THRESH_CYC),
        .MIN_HIGH_CYC (MIN_HIGH_CYC),
        .MAX_HIGH_CYC (MAX_HIGH_CYC),
        .RESET_CYC    (RESET_CYC)
    ) u_slicer (
        .clk        (clk),
        .res_n      (res_n),
        .din        (din),
        .din_s      (w_din_s),
        .bit_val    (w_ev.bit_val),
        .bit_strobe (w_ev.bit_strobe),
        .glitch     (w_ev.glitch),
        .stuck      (w_ev.stuck),
        .gap        (w_ev.gap)
    );

    assign w_next_shift = shift_in_bit(r_shift, w_ev.bit_val);

    // Frame FSM: capture own pixel, then forward; a gap always resynchronises
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state     <= c_st_rx_own;
            r_bit_idx   <= 5'd0;
            r_shift     <= 24'd0;
            pixel_grb   <= 24'd0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_err     <= 1'b0;
            dout        <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            dout        <= 1'b0;

            if (w_ev.gap) begin
                // A partial pixel is dropped silently; pixel_grb keeps its value
                frame_done <= 1'b1;
                r_state    <= c_st_rx_own;
                r_bit_idx  <= 5'd0;
                bit_err    <= 1'b0;
            end else begin
                case (r_state)
                    c_st_rx_own: begin
                        if (w_ev.glitch || w_ev.stuck) begin
                            r_state <= c_st_error;
                            bit_err <= 1'b1;
                        end else if (w_ev.bit_strobe) begin
                            r_shift <= w_next_shift;
                            if (r_bit_idx == c_last_bit_idx) begin
                                pixel_grb   <= w_next_shift;
                                pixel_valid <= 1'b1;
                                r_bit_idx   <= 5'd0;
                                r_state     <= c_st_forward;
                            end else begin
                                r_bit_idx <= r_bit_idx + 5'd1;
                            end
                        end
                    end
                    c_st_forward: begin
                        if (w_ev.glitch || w_ev.stuck) begin
                            r_state <= c_st_error;
                            bit_err <= 1'b1;
                        end else begin
                            dout <= w_din_s;
                        end
                    end
                    c_st_error: begin
                        // Hold until the next gap
                    end
                    default: begin
                        r_state <= c_st_rx_own;
                    end
                endcase
            end
        end
    end

    assign busy = (r_state != c_st_error) &&
                  ((r_bit_idx != 5'd0) || (r_state == c_st_forward));

endmodule : ws2812b_pixel_rx
`default_nettype wire

// File: tb/tb_ws2812b_pixel_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812b_pixel_rx
// Description : Directed self-checking bench for ws2812b_pixel_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812b_pixel_rx;
    import ws2812b_pkg::*;

    logic        clk   = 1'b0;
    logic        res_n = 1'b0;
    logic        din   = 1'b0;
    logic        dout;
    logic [23:0] pixel_grb;
    logic        pixel_valid;
    logic        frame_done;
    logic        bit_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Event counters maintained by the monitor
    int   pv_cnt   = 0;
    int   fd_cnt   = 0;
    int   rise_cnt = 0;
    int   fwd_mis  = 0;
    logic dout_q   = 1'b0;
    logic mon_en   = 1'b0;
    logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

    always #5 clk = ~clk;

    ws2812b_pixel_rx dut (
        .clk         (clk),
        .res_n       (res_n),
        .din         (din),
        .dout        (dout),
        .pixel_grb   (pixel_grb),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .bit_err     (bit_err),
        .busy        (busy)
    );

    // din as seen at each rising edge; dout must equal the value two edges back
    always @(posedge clk) begin
        h0 <= din;
        h1 <= h0;
        h2 <= h1;
    end

    // Count output events and forwarding mismatches
    always @(negedge clk) begin
        dout_q <= dout;
        if (pixel_valid === 1'b1) pv_cnt <= pv_cnt + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (dout === 1'b1 && dout_q === 1'b0) rise_cnt <= rise_cnt + 1;
        if (mon_en && (dout !== h2)) fwd_mis <= fwd_mis + 1;
    end

    task automatic send_hi(input logic b);
        din = 1'b1;
        repeat (b ? c_t1h_cyc : c_t0h_cyc) @(negedge clk);
        din = 1'b0;
    endtask

    task automatic low(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        send_hi(b);
        low(b ? c_t1l_cyc : c_t0l_cyc);
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(w[23-i]);
    endtask

    task automatic test_reset;
        res_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dout, pixel_valid, frame_done, bit_err, busy, pixel_grb} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {dout, pixel_valid, frame_done, bit_err, busy, pixel_grb});
        end
        res_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pixel;
        logic [23:0] w;
        int pv0, fd0;
        w = 24'hFF0000;
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        send_bits(w, 0, 9);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_mid got %b want 1", busy); end
        send_bits(w, 10, 22);
        send_hi(w[0]);
        low(2);
        checks++;
        if (pixel_valid !== 1'b0) begin errors++; $display("FAIL t1_pv_early got %b want 0", pixel_valid); end
        low(1);
        checks++;
        if (pixel_valid !== 1'b1) begin errors++; $display("FAIL t1_pv_at3 got %b want 1", pixel_valid); end
        low(1);
        checks++;
        if (pixel_valid !== 1'b0) begin errors++; $display("FAIL t1_pv_pulse got %b want 0", pixel_valid); end
        low(396);
        checks++;
        if (fd_cnt !== fd0) begin errors++; $display("FAIL t1_fd_early got %0d want %0d", fd_cnt, fd0); end
        low(200);
        checks++;
        if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL t1_fd_once got %0d want %0d", fd_cnt, fd0 + 1); end
        checks++;
        if (pixel_grb !== 24'hFF0000) begin errors++; $display("FAIL t1_grb got %h want ff0000", pixel_grb); end
        checks++;
        if (pv_cnt !== pv0 + 1) begin errors++; $display("FAIL t1_pv_count got %0d want %0d", pv_cnt, pv0 + 1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_forward;
        int pv0, r0, r1, m0;
        pv0 = pv_cnt;
        r0  = rise_cnt;
        send_bits(24'h00AA55, 0, 23);
        checks++;
        if (rise_cnt !== r0) begin errors++; $display("FAIL t2_dout_quiet got %0d want %0d", rise_cnt, r0); end
        checks++;
        if (pixel_grb !== 24'h00AA55) begin errors++; $display("FAIL t2_grb got %h want 00aa55", pixel_grb); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL t2_busy_fwd got %b want 1", busy); end
        r1 = rise_cnt;
        m0 = fwd_mis;
        mon_en = 1'b1;
        send_bits(24'h123456, 0, 23);
        low(600);
        mon_en = 1'b0;
        @(negedge clk);
        checks++;
        if (rise_cnt - r1 !== 24) begin errors++; $display("FAIL t2_fwd_pulses got %0d want 24", rise_cnt - r1); end
        checks++;
        if (fwd_mis !== m0) begin errors++; $display("FAIL t2_fwd_shape got %0d want 0 mismatched cycles", fwd_mis - m0); end
        checks++;
        if (pixel_grb !== 24'h00AA55) begin errors++; $display("FAIL t2_grb_held got %h want 00aa55", pixel_grb); end
        checks++;
        if (pv_cnt !== pv0 + 1) begin errors++; $display("FAIL t2_pv_count got %0d want %0d", pv_cnt, pv0 + 1); end
    endtask

    task automatic test_glitch;
        int pv0, fd0, r0;
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        r0  = rise_cnt;
        send_bits(24'h0F0F0F, 0, 4);
        din = 1'b1;
        @(negedge clk);
        din = 1'b0;
        low(10);
        checks++;
        if (bit_err !== 1'b1) begin errors++; $display("FAIL t3_err_set got %b want 1", bit_err); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy_err got %b want 0", busy); end
        send_bits(24'h0F0F0F, 5, 23);
        low(20);
        checks++;
        if (pv_cnt !== pv0) begin errors++; $display("FAIL t3_no_capture got %0d want %0d", pv_cnt, pv0); end
        checks++;
        if (rise_cnt !== r0) begin errors++; $display("FAIL t3_dout_quiet got %0d want %0d", rise_cnt, r0); end
        low(600);
        checks++;
        if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL t3_fd got %0d want %0d", fd_cnt, fd0 + 1); end
        checks++;
        if (bit_err !== 1'b0) begin errors++; $display("FAIL t3_err_clear got %b want 0", bit_err); end
        send_bits(24'h0F0F0F, 0, 23);
        low(20);
        checks++;
        if (pixel_grb !== 24'h0F0F0F) begin errors++; $display("FAIL t3_recover_grb got %h want 0f0f0f", pixel_grb); end
        checks++;
        if (pv_cnt !== pv0 + 1) begin errors++; $display("FAIL t3_recover_pv got %0d want %0d", pv_cnt, pv0 + 1); end
        low(600);
    endtask

    task automatic test_stuck;
        int pv0, fd0;
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        send_bits(24'hFFFFFF, 0, 7);
        din = 1'b1;
        low(10);
        checks++;
        if (bit_err !== 1'b0) begin errors++; $display("FAIL t4_err_early got %b want 0", bit_err); end
        low(10);
        checks++;
        if (bit_err !== 1'b1) begin errors++; $display("FAIL t4_err_stuck got %b want 1", bit_err); end
        low(10);
        din = 1'b0;
        low(600);
        checks++;
        if (fd_cnt !== fd0 + 1 || bit_err !== 1'b0) begin
            errors++;
            $display("FAIL t4_gap_clear got fd=%0d err=%b want fd=%0d err=0", fd_cnt, bit_err, fd0 + 1);
        end
        send_bits(24'h3C5A96, 0, 23);
        low(20);
        checks++;
        if (pixel_grb !== 24'h3C5A96 || pv_cnt !== pv0 + 1) begin
            errors++;
            $display("FAIL t4_recover got grb=%h pv=%0d want grb=3c5a96 pv=%0d", pixel_grb, pv_cnt, pv0 + 1);
        end
        low(600);
    endtask

    task automatic test_gap;
        logic [23:0] wa, wb, wc;
        int pv0, fd0;
        wa = 24'hC3A517;
        wb = 24'h5A5A5A;
        wc = 24'h81C3E7;
        // 499-cycle low does not end the frame
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        send_bits(wa, 0, 10);
        send_hi(wa[12]);
        low(499);
        checks++;
        if (fd_cnt !== fd0) begin errors++; $display("FAIL t5_short_gap_fd got %0d want %0d", fd_cnt, fd0); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL t5_short_gap_busy got %b want 1", busy); end
        send_bits(wa, 12, 23);
        low(20);
        checks++;
        if (pixel_grb !== wa || pv_cnt !== pv0 + 1) begin
            errors++;
            $display("FAIL t5_continued got grb=%h pv=%0d want grb=%h pv=%0d", pixel_grb, pv_cnt, wa, pv0 + 1);
        end
        low(600);
        // 500-cycle low ends the frame and drops the partial pixel
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        send_bits(wb, 0, 10);
        send_hi(wb[12]);
        low(510);
        checks++;
        if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL t5_gap_fd got %0d want %0d", fd_cnt, fd0 + 1); end
        checks++;
        if (pixel_grb !== wa || pv_cnt !== pv0) begin
            errors++;
            $display("FAIL t5_partial_dropped got grb=%h pv=%0d want grb=%h pv=%0d", pixel_grb, pv_cnt, wa, pv0);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t5_gap_busy got %b want 0", busy); end
        send_bits(wc, 0, 23);
        low(20);
        checks++;
        if (pixel_grb !== wc || pv_cnt !== pv0 + 1) begin
            errors++;
            $display("FAIL t5_restart got grb=%h pv=%0d want grb=%h pv=%0d", pixel_grb, pv_cnt, wc, pv0 + 1);
        end
        low(600);
    endtask

    task automatic test_reset_mid;
        int pv0;
        send_bits(24'h123456, 0, 11);
        res_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout, pixel_valid, frame_done, bit_err, busy, pixel_grb} !== 29'd0) begin
            errors++;
            $display("FAIL t6_reset_outputs got %h want 0",
                     {dout, pixel_valid, frame_done, bit_err, busy, pixel_grb});
        end
        res_n = 1'b1;
        low(5);
        pv0 = pv_cnt;
        send_bits(24'hABCDEF, 0, 23);
        low(20);
        checks++;
        if (pixel_grb !== 24'hABCDEF || pv_cnt !== pv0 + 1) begin
            errors++;
            $display("FAIL t6_fresh got grb=%h pv=%0d want grb=abcdef pv=%0d", pixel_grb, pv_cnt, pv0 + 1);
        end
        low(600);
    endtask

    initial begin
        test_reset;
        test_single_pixel;
        test_forward;
        test_glitch;
        test_stuck;
        test_gap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ws2812b_pixel_rx
`default_nettype wire
